// File: rtl/loader_pkg.sv
// rtl/loader_pkg.sv - shared state encoding and sizing for the program loader
// LOADER_CHECKSUM_EN adds the CHECK state; the encoding is present in every build.
package loader_pkg;

  localparam int BYTES_PER_WORD = 4;
  localparam int CSUM_W         = 8;

  typedef enum logic [2:0] {
    ST_HDR,
    ST_RECV,
    ST_WRITE,
    ST_CHECK,
    ST_RUN,
    ST_ERROR
  } state_e;

  function automatic int max_words(input int addr_w);
    return 1 << addr_w;
  endfunction

endpackage

// File: rtl/byte_assembler.sv
// rtl/byte_assembler.sv - MSB-first byte-to-word shift register with byte position counter
module byte_assembler
  import loader_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              shift_en,
  input  logic              clear,
  input  logic [7:0]        din,
  output logic [DATA_W-1:0] word,
  output logic              word_full
);

  logic [1:0]        cnt_q, cnt_d;
  logic [DATA_W-1:0] word_q, word_d;

  always_comb begin
    cnt_d  = cnt_q;
    word_d = word_q;
    if (clear) begin
      cnt_d  = 2'd0;
      word_d = '0;
    end else if (shift_en) begin
      cnt_d  = cnt_q + 2'd1;
      word_d = {word_q[DATA_W-9:0], din};
    end
  end

  // Flags the byte that completes the word, so the FSM can leave RECV on that edge.
  assign word_full = shift_en & ~clear & (cnt_q == 2'(BYTES_PER_WORD - 1));
  assign word      = word_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q  <= 2'd0;
      word_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      word_q <= word_d;
    end
  end

endmodule

// File: rtl/program_loader.sv
// rtl/program_loader.sv - byte-stream instruction memory loader gating the core's run enable
// Optional trailing checksum byte and CHECK state when LOADER_CHECKSUM_EN is defined.
module program_loader
  import loader_pkg::*;
#(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 32
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              rx_ready,
  input  logic              load_req,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [DATA_W-1:0] imem_wdata,
  output logic              cpu_run,
  output logic              load_done,
  output logic              load_error,
  output logic              busy
);

  localparam int MAX_WORDS = max_words(ADDR_W);
  localparam int CNT_W     = ADDR_W + 1;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   n_q, n_d;
  logic [CNT_W-1:0]   idx_q, idx_d;
  logic               done_q, done_d;
  logic               accept, shift_en, asm_clear, word_full;
  logic [8:0]         hdr_n;
`ifdef LOADER_CHECKSUM_EN
  logic [CSUM_W-1:0]  sum_q, sum_d;
`endif

  assign rx_ready = (state_q == ST_HDR) || (state_q == ST_RECV) || (state_q == ST_CHECK);
  assign accept   = rx_valid & rx_ready;
  assign hdr_n    = (rx_data == 8'd0) ? 9'(MAX_WORDS) : {1'b0, rx_data};

  always_comb begin
    state_d   = state_q;
    n_d       = n_q;
    idx_d     = idx_q;
    done_d    = 1'b0;
    shift_en  = 1'b0;
    asm_clear = 1'b0;
`ifdef LOADER_CHECKSUM_EN
    sum_d     = sum_q;
`endif
    case (state_q)
      ST_HDR: begin
        if (accept) begin
          if (hdr_n > 9'(MAX_WORDS)) begin
            state_d = ST_ERROR;
          end else begin
            n_d     = hdr_n[CNT_W-1:0];
            state_d = ST_RECV;
          end
`ifdef LOADER_CHECKSUM_EN
          sum_d = rx_data;
`endif
        end
      end
      ST_RECV: begin
        shift_en = accept;
        if (word_full) state_d = ST_WRITE;
`ifdef LOADER_CHECKSUM_EN
        if (accept) sum_d = sum_q + rx_data;
`endif
      end
      ST_WRITE: begin
        idx_d = idx_q + CNT_W'(1);
        if (idx_q == n_q - CNT_W'(1)) begin
`ifdef LOADER_CHECKSUM_EN
          state_d = ST_CHECK;
`else
          state_d = ST_RUN;
          done_d  = 1'b1;
`endif
        end else begin
          state_d = ST_RECV;
        end
      end
`ifdef LOADER_CHECKSUM_EN
      ST_CHECK: begin
        if (accept) begin
          if (rx_data == sum_q) begin
            state_d = ST_RUN;
            done_d  = 1'b1;
          end else begin
            state_d = ST_ERROR;
          end
        end
      end
`endif
      // cpu_run drops on the same edge that returns to HDR, before any write can occur.
      ST_RUN, ST_ERROR: begin
        if (load_req) begin
          state_d   = ST_HDR;
          idx_d     = '0;
          asm_clear = 1'b1;
`ifdef LOADER_CHECKSUM_EN
          sum_d     = '0;
`endif
        end
      end
      default: state_d = ST_HDR;
    endcase
  end

  byte_assembler #(.DATA_W(DATA_W)) u_asm (
    .clock     (clock),
    .reset_n   (reset_n),
    .shift_en  (shift_en),
    .clear     (asm_clear),
    .din       (rx_data),
    .word      (imem_wdata),
    .word_full (word_full)
  );

  assign imem_we    = (state_q == ST_WRITE);
  assign imem_addr  = idx_q[ADDR_W-1:0];
  assign cpu_run    = (state_q == ST_RUN);
  assign load_error = (state_q == ST_ERROR);
  assign busy       = (state_q == ST_HDR) || (state_q == ST_RECV) ||
                      (state_q == ST_WRITE) || (state_q == ST_CHECK);
  assign load_done  = done_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_HDR;
      n_q     <= '0;
      idx_q   <= '0;
      done_q  <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      sum_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      idx_q   <= idx_d;
      done_q  <= done_d;
`ifdef LOADER_CHECKSUM_EN
      sum_q   <= sum_d;
`endif
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// tb/tb_program_loader.sv - directed self-checking bench for program_loader
module tb_program_loader;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_ready;
  logic        load_req = 1'b0;
  logic        imem_we;
  logic [5:0]  imem_addr;
  logic [31:0] imem_wdata;
  logic        cpu_run, load_done, load_error, busy;

  program_loader #(.ADDR_W(6), .DATA_W(32)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .rx_valid   (rx_valid),
    .rx_data    (rx_data),
    .rx_ready   (rx_ready),
    .load_req   (load_req),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .cpu_run    (cpu_run),
    .load_done  (load_done),
    .load_error (load_error),
    .busy       (busy)
  );

  always #5 clock = ~clock;

  int          errors = 0;
  int          checks = 0;
  int          done_cnt = 0;
  int          ready_bad = 0;
  logic [31:0] wa[$];
  logic [31:0] wd[$];
  logic [31:0] mem [0:63];
  logic [31:0] wbuf [0:63];
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]  csum_delta = 8'h00;
`endif

  // Write-port monitor, sampled just after each rising edge.
  always @(posedge clock) begin
    #1;
    if (imem_we === 1'b1) begin
      wa.push_back(32'(imem_addr));
      wd.push_back(imem_wdata);
      mem[imem_addr] = imem_wdata;
      if (rx_ready !== 1'b0) ready_bad++;
    end
    if (load_done === 1'b1) done_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic send_byte(input logic [7:0] b);
    int g = 0;
    rx_valid = 1'b1;
    rx_data  = b;
    while (rx_ready !== 1'b1 && g < 50) begin
      @(negedge clock);
      g++;
    end
    if (g >= 50) chk("ready_timeout", 32'(rx_ready), 32'd1);
    @(negedge clock);
    rx_valid = 1'b0;
  endtask

  task automatic load_words(input int n_byte, input int k, input int gap_max, input bit poke_req);
    int g = 0;
    logic [7:0] b;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0] sum;
    sum = 8'(n_byte);
`endif
    wa.delete();
    wd.delete();
    done_cnt = 0;
    send_byte(8'(n_byte));
    for (int i = 0; i < k; i++) begin
      for (int j = 0; j < 4; j++) begin
        b = wbuf[i][31-8*j -: 8];
`ifdef LOADER_CHECKSUM_EN
        sum = sum + b;
`endif
        send_byte(b);
        if (gap_max > 0) idle($urandom_range(gap_max, 0));
        if (poke_req && i == 0 && j == 1) begin
          load_req = 1'b1;
          idle(2);
          load_req = 1'b0;
          chk("recv_req_busy", 32'(busy), 32'd1);
          chk("recv_req_run", 32'(cpu_run), 32'd0);
        end
      end
    end
`ifdef LOADER_CHECKSUM_EN
    send_byte(sum + csum_delta);
`endif
    while (cpu_run !== 1'b1 && load_error !== 1'b1 && g < 100) begin
      @(negedge clock);
      g++;
    end
    if (g >= 100) chk("load_timeout", 32'(cpu_run), 32'd1);
  endtask

  task automatic do_reload();
    load_req = 1'b1;
    @(posedge clock);
    #1;
    chk("reload_run_drop", 32'(cpu_run), 32'd0);
    chk("reload_busy", 32'(busy), 32'd1);
    load_req = 1'b0;
    @(negedge clock);
  endtask

  initial begin
    // Reset values
    idle(2);
    chk("rst_we", 32'(imem_we), 32'd0);
    chk("rst_addr", 32'(imem_addr), 32'd0);
    chk("rst_wdata", imem_wdata, 32'd0);
    chk("rst_run", 32'(cpu_run), 32'd0);
    chk("rst_done", 32'(load_done), 32'd0);
    chk("rst_err", 32'(load_error), 32'd0);
    chk("rst_busy", 32'(busy), 32'd1);
    chk("rst_ready", 32'(rx_ready), 32'd1);
    reset_n = 1'b1;
    idle(1);

    // Basic load, back-to-back bytes
    wbuf[0] = 32'h8C000001;
    wbuf[1] = 32'hFC000000;
    load_words(2, 2, 0, 1'b0);
    chk("basic_done_with_run", 32'(load_done), 32'd1);
    chk("basic_nw", 32'(wa.size()), 32'd2);
    chk("basic_a0", wa[0], 32'd0);
    chk("basic_d0", wd[0], 32'h8C000001);
    chk("basic_a1", wa[1], 32'd1);
    chk("basic_d1", wd[1], 32'hFC000000);
    idle(1);
    chk("basic_done_pulse", 32'(load_done), 32'd0);
    chk("basic_done_cnt", 32'(done_cnt), 32'd1);
    chk("basic_run", 32'(cpu_run), 32'd1);
    chk("basic_busy", 32'(busy), 32'd0);
    chk("basic_ready", 32'(rx_ready), 32'd0);
    chk("basic_err", 32'(load_error), 32'd0);

    // Reload of one word; load_req during RECV is ignored
    do_reload();
    wbuf[0] = 32'h11223344;
    load_words(1, 1, 0, 1'b1);
    chk("reload_nw", 32'(wa.size()), 32'd1);
    chk("reload_a0", wa[0], 32'd0);
    chk("reload_d0", wd[0], 32'h11223344);
    chk("reload_keep1", mem[1], 32'hFC000000);
    chk("reload_run", 32'(cpu_run), 32'd1);

    // Random gaps between bytes
    do_reload();
    wbuf[0] = 32'hA5A50F0F;
    wbuf[1] = 32'h12345678;
    wbuf[2] = 32'h000000FF;
    load_words(3, 3, 3, 1'b0);
    chk("gap_nw", 32'(wa.size()), 32'd3);
    for (int i = 0; i < 3; i++) begin
      chk("gap_addr", wa[i], 32'(i));
      chk("gap_data", wd[i], wbuf[i]);
    end
    chk("gap_run", 32'(cpu_run), 32'd1);

    // N=65 is out of range
    do_reload();
    wa.delete();
    done_cnt = 0;
    send_byte(8'h41);
    idle(3);
    chk("n65_err", 32'(load_error), 32'd1);
    chk("n65_run", 32'(cpu_run), 32'd0);
    chk("n65_busy", 32'(busy), 32'd0);
    chk("n65_ready", 32'(rx_ready), 32'd0);
    chk("n65_nw", 32'(wa.size()), 32'd0);
    chk("n65_done", 32'(done_cnt), 32'd0);
    load_req = 1'b1;
    @(negedge clock);
    load_req = 1'b0;
    chk("err_clear", 32'(load_error), 32'd0);
    chk("err_hdr_busy", 32'(busy), 32'd1);

    // N=0 loads the full 64 words
    for (int i = 0; i < 64; i++) wbuf[i] = {8'(i), 8'hC3, ~8'(i), 8'(i * 3)};
    load_words(0, 64, 0, 1'b0);
    chk("full_nw", 32'(wa.size()), 32'd64);
    for (int i = 0; i < 64; i++) begin
      chk("full_addr", wa[i], 32'(i));
      chk("full_data", wd[i], wbuf[i]);
    end
    chk("full_run", 32'(cpu_run), 32'd1);

    // Asynchronous reset after 6 data bytes
    do_reload();
    send_byte(8'h02);
    for (int i = 1; i <= 6; i++) send_byte(8'(i));
    chk("mid_addr_pre", 32'(imem_addr), 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("mid_rst_we", 32'(imem_we), 32'd0);
    chk("mid_rst_addr", 32'(imem_addr), 32'd0);
    chk("mid_rst_wdata", imem_wdata, 32'd0);
    chk("mid_rst_run", 32'(cpu_run), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd1);
    chk("mid_rst_ready", 32'(rx_ready), 32'd1);
    @(negedge clock);
    reset_n = 1'b1;
    idle(1);
    wbuf[0] = 32'hDEADBEEF;
    load_words(1, 1, 0, 1'b0);
    chk("mid_nw", 32'(wa.size()), 32'd1);
    chk("mid_a0", wa[0], 32'd0);
    chk("mid_d0", wd[0], 32'hDEADBEEF);
    chk("mid_run", 32'(cpu_run), 32'd1);

`ifdef LOADER_CHECKSUM_EN
    // Checksum match and mismatch
    do_reload();
    wbuf[0] = 32'h00000001;
    load_words(1, 1, 0, 1'b0);
    chk("csum_ok_run", 32'(cpu_run), 32'd1);
    chk("csum_ok_err", 32'(load_error), 32'd0);
    do_reload();
    csum_delta = 8'h01;
    load_words(1, 1, 0, 1'b0);
    csum_delta = 8'h00;
    chk("csum_bad_err", 32'(load_error), 32'd1);
    chk("csum_bad_run", 32'(cpu_run), 32'd0);
    chk("csum_bad_nw", 32'(wa.size()), 32'd1);
    chk("csum_bad_d0", wd[0], 32'h00000001);
    idle(2);
    chk("csum_bad_done", 32'(done_cnt), 32'd0);
`endif

    chk("ready_low_in_write", 32'(ready_bad), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/program_loader.md
Name: program_loader

Overview:
- Upstream stage of the single-cycle processor. Fills the instruction memory (64 x 32-bit words, 6-bit word address) from a byte stream, then releases the core to run.
- Accepts a byte-wide valid/ready stream and assembles 4 bytes, MSB first, into each instruction word.
- Drives the instruction-memory write port and the core's run/hold enable.

Parameters:
- ADDR_W, 6, instruction-memory word address width; capacity MAX_WORDS = 2**ADDR_W.
- DATA_W, 32, instruction word width; must equal 4*8.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- rx_valid  in  1  byte available on rx_data.
- rx_data  in  8  stream byte.
- rx_ready  out  1  loader accepts the byte this cycle; a transfer occurs on rx_valid & rx_ready.
- load_req  in  1  request a reload; honoured only in RUN or ERROR.
- imem_we  out  1  instruction-memory write strobe, one cycle per word.
- imem_addr  out  ADDR_W  word address for the write.
- imem_wdata  out  DATA_W  assembled word.
- cpu_run  out  1  high lets the core's PC advance; low holds the core.
- load_done  out  1  one-cycle pulse on entering RUN.
- load_error  out  1  high while in ERROR.
- busy  out  1  high in HDR, RECV, WRITE and CHECK.

Behaviour:
- Reset: reset_n is asynchronous and active-low.
  - State -> HDR; word and byte counters cleared.
  - imem_we=0, imem_addr=0, imem_wdata=0, cpu_run=0, load_done=0, load_error=0, busy=1.
  - rx_ready=1, since it is decoded from state.
- rx_ready is 1 in HDR, RECV and CHECK, and 0 in WRITE, RUN and ERROR.
- HDR: the first accepted byte is the word count N.
  - N=0 means MAX_WORDS.
  - N>MAX_WORDS -> ERROR.
  - Otherwise latch N and go to RECV.
- RECV: shift accepted bytes into the word register, MSB first; a 2-bit byte counter tracks position.
  - On the 4th byte, go to WRITE.
  - rx_valid low leaves state and counters unchanged; gaps of any length are legal.
- WRITE: exactly one cycle with imem_we=1, imem_addr=word index (0-based), imem_wdata=assembled word.
  - Word index increments.
  - If the index was N-1: go to CHECK when LOADER_CHECKSUM_EN is defined, else RUN. Otherwise return to RECV.
  - Minimum latency is 4 accepted bytes plus 1 write cycle per word.
- RUN: cpu_run=1. The cycle that enters RUN also pulses load_done.
  - load_req=1 -> HDR next cycle. cpu_run drops in that same edge, so the core is held before any write.
- ERROR: load_error=1 and cpu_run=0; sticky.
  - load_req -> HDR and clear the counters.
- load_req is ignored in HDR, RECV, WRITE and CHECK.
- Memory words not written by the current load keep their previous contents; no clearing pass.
- Reset mid-load: the load is abandoned immediately; cpu_run stays 0 until a full new load completes.
- Word index is ADDR_W+1 bits internally so N=MAX_WORDS terminates without wrap. imem_addr is the low ADDR_W bits.

Optional Feature:
- Macro: LOADER_CHECKSUM_EN.
- Defined:
  - An 8-bit running sum (mod 256) covers the count byte and all data bytes.
  - In CHECK, one further byte is accepted. Equal to the sum -> RUN; different -> ERROR.
  - The words are already written on a mismatch; the core is never released.
- Not defined:
  - No CHECK state and no sum register; WRITE of the last word goes directly to RUN.

Decomposition:
- Package loader_pkg:
  - State encoding: HDR, RECV, WRITE, CHECK, RUN, ERROR.
  - BYTES_PER_WORD=4.
  - MAX_WORDS function of ADDR_W.
  - Checksum width 8.
- Sub-module byte_assembler: 32-bit shift register plus 2-bit byte counter, with inputs shift_en and clear and outputs word and word_full.
- The FSM, word counter and checksum stay in program_loader.

Test Plan:
- Basic load: N=2, bytes 8C 00 00 01 FC 00 00 00 with no gaps.
  - Two one-cycle imem_we pulses: addr 0 data 0x8C000001, addr 1 data 0xFC000000.
  - load_done pulses once, then cpu_run=1.
- Boundary counts:
  - N=0 followed by 256 bytes -> 64 writes at addr 0..63, then RUN.
  - N=65 -> ERROR, load_error=1, no imem_we.
- Back-pressure: rx_valid held high continuously.
  - rx_ready=0 in each WRITE cycle, and no byte is lost or duplicated.
  - Random rx_valid gaps produce identical writes.
- Reset mid-load: reset_n pulsed low after 6 data bytes.
  - Outputs go to their reset values asynchronously, and the next load starts at addr 0.
- Reload: load_req in RUN -> cpu_run=0 on the next edge, state HDR, and a second load overwrites only its N words.
  - load_req in RECV has no effect.
- With LOADER_CHECKSUM_EN, N=1, word 0x00000001:
  - Checksum byte 0x02 -> RUN.
  - Checksum byte 0x03 -> ERROR; the word is written but cpu_run stays 0.
